// File: rtl/mux_nx1_scan.sv
// N-channel, W-bit registered mux with a manual select mode and an automatic scan mode.
// Optional feature macro MUX_SCAN_SKIP_MASK_EN adds en_mask so the scan skips disabled channels.
module mux_nx1_scan #(
   parameter int unsigned N       = 8,
   parameter int unsigned W       = 1,
   parameter int unsigned SEL_W   = $clog2(N),
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*W-1:0]     din,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel_in,
   input  logic               load,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               start,
   input  logic               stop,
`ifdef MUX_SCAN_SKIP_MASK_EN
   input  logic [N-1:0]       en_mask,
`endif
   output logic [W-1:0]       y,
   output logic [SEL_W-1:0]   y_ch,
   output logic               valid,
   output logic               busy,
   output logic               wrap,
   output logic               err
);

   localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(N);
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(N-1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   ch, ch_nxt;
   logic [DWELL_W-1:0] cnt, cnt_nxt;
   logic [DWELL_W-1:0] dwell_q, dwell_nxt;
   logic [W-1:0]       y_nxt;
   logic [SEL_W-1:0]   y_ch_nxt;
   logic               valid_nxt, busy_nxt, wrap_nxt, err_nxt;

   logic [W-1:0]       mux_c;
   logic               sel_bad_c;
   logic [SEL_W-1:0]   adv_ch_c;
   logic               adv_wrap_c;
   logic               adv_ok_c;
   logic [SEL_W-1:0]   start_ch_c;

   // Channel data selected by the current channel register
   always_comb begin
      mux_c = '0;
      for (int k = 0; k < int'(N); k++) begin
         if (ch == SEL_W'(k)) mux_c = din[k*W +: W];
      end
   end

   assign sel_bad_c = ({1'b0, sel_in} >= N_EXT);

`ifdef MUX_SCAN_SKIP_MASK_EN
   logic             hi_ok_c, any_en_c;
   logic [SEL_W-1:0] hi_ch_c, low_ch_c;

   // Nearest enabled channel above ch, else wrap to the lowest enabled channel
   always_comb begin
      hi_ok_c  = 1'b0;
      hi_ch_c  = '0;
      any_en_c = 1'b0;
      low_ch_c = '0;
      for (int j = int'(N) - 1; j >= 0; j--) begin
         if (en_mask[j]) begin
            any_en_c = 1'b1;
            low_ch_c = SEL_W'(j);
            if (SEL_W'(j) > ch) begin
               hi_ok_c = 1'b1;
               hi_ch_c = SEL_W'(j);
            end
         end
      end
   end

   assign adv_ch_c   = hi_ok_c ? hi_ch_c : low_ch_c;
   assign adv_wrap_c = any_en_c && !hi_ok_c;
   assign adv_ok_c   = any_en_c;
   assign start_ch_c = low_ch_c;
`else
   assign adv_ch_c   = (ch == LAST) ? '0 : ch + 1'b1;
   assign adv_wrap_c = (ch == LAST);
   assign adv_ok_c   = 1'b1;
   assign start_ch_c = '0;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      cnt_nxt   = cnt;
      dwell_nxt = dwell_q;
      y_nxt     = y;
      y_ch_nxt  = y_ch;
      valid_nxt = valid;
      wrap_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            valid_nxt = 1'b0;
            if (start && !stop) begin
               if (mode) begin
                  state_nxt = ST_SCAN;
                  ch_nxt    = start_ch_c;
                  cnt_nxt   = '0;
                  dwell_nxt = dwell;
               end else begin
                  state_nxt = ST_MANUAL;
                  err_nxt   = sel_bad_c;
                  ch_nxt    = sel_bad_c ? '0 : sel_in;
               end
            end
         end
         ST_MANUAL: begin
            if (stop) begin
               state_nxt = ST_IDLE;
               valid_nxt = 1'b0;
            end else begin
               y_nxt     = mux_c;
               y_ch_nxt  = ch;
               valid_nxt = 1'b1;
               if (load) begin
                  if (sel_bad_c) err_nxt = 1'b1;
                  else           ch_nxt  = sel_in;
               end
            end
         end
         ST_SCAN: begin
            if (stop) begin
               state_nxt = ST_IDLE;
               valid_nxt = 1'b0;
            end else begin
               y_nxt     = mux_c;
               y_ch_nxt  = ch;
               valid_nxt = adv_ok_c;
               cnt_nxt   = cnt + 1'b1;
               if (cnt == dwell_q) begin
                  cnt_nxt = '0;
                  if (adv_ok_c) begin
                     ch_nxt   = adv_ch_c;
                     wrap_nxt = adv_wrap_c;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ch      <= '0;
         cnt     <= '0;
         dwell_q <= '0;
         y       <= '0;
         y_ch    <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         wrap    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         ch      <= ch_nxt;
         cnt     <= cnt_nxt;
         dwell_q <= dwell_nxt;
         y       <= y_nxt;
         y_ch    <= y_ch_nxt;
         valid   <= valid_nxt;
         busy    <= busy_nxt;
         wrap    <= wrap_nxt;
         err     <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Self-checking bench for mux_nx1_scan: an N=8 and an N=5 instance (W=4) share clock and controls.
module tb_mux_nx1_scan;

   logic        clk = 1'b0;
   logic        rst, mode, load, start, stop;
   logic [2:0]  sel_in;
   logic [7:0]  dwell;
   logic [31:0] din8;
   logic [19:0] din5;
   logic [3:0]  y8, y5;
   logic [2:0]  ych8, ych5;
   logic        valid8, busy8, wrap8, err8;
   logic        valid5, busy5, wrap5, err5;
`ifdef MUX_SCAN_SKIP_MASK_EN
   logic [7:0]  en_mask8;
   logic [4:0]  en_mask5;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux_nx1_scan #(.N(8), .W(4)) dut8 (
      .clk(clk), .rst(rst), .din(din8), .mode(mode), .sel_in(sel_in), .load(load),
      .dwell(dwell), .start(start), .stop(stop),
`ifdef MUX_SCAN_SKIP_MASK_EN
      .en_mask(en_mask8),
`endif
      .y(y8), .y_ch(ych8), .valid(valid8), .busy(busy8), .wrap(wrap8), .err(err8));

   mux_nx1_scan #(.N(5), .W(4)) dut5 (
      .clk(clk), .rst(rst), .din(din5), .mode(mode), .sel_in(sel_in), .load(load),
      .dwell(dwell), .start(start), .stop(stop),
`ifdef MUX_SCAN_SKIP_MASK_EN
      .en_mask(en_mask5),
`endif
      .y(y5), .y_ch(ych5), .valid(valid5), .busy(busy5), .wrap(wrap5), .err(err5));

   function automatic logic [3:0] pick8(input logic [31:0] d, input int k);
      return d[k*4 +: 4];
   endfunction

   function automatic logic [3:0] pick5(input logic [19:0] d, input int k);
      return d[k*4 +: 4];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total++;
      if ({y8, ych8, valid8, busy8, wrap8, err8} !== 11'd0) begin
         bad++;
         $display("FAIL reset8 got=%h exp=0", {y8, ych8, valid8, busy8, wrap8, err8});
      end
      total++;
      if ({y5, ych5, valid5, busy5, wrap5, err5} !== 11'd0) begin
         bad++;
         $display("FAIL reset5 got=%h exp=0", {y5, ych5, valid5, busy5, wrap5, err5});
      end
   endtask

   task automatic test_manual();
      int          ch_m;
      logic [19:0] pd;
      int          pch;
      logic        exp_err;
      for (int k = 0; k < 8; k++) din8[k*4 +: 4] = 4'(k + 3);
      for (int k = 0; k < 5; k++) din5[k*4 +: 4] = 4'(k + 3);
      // start manual with sel 5: legal for N=8, out of range for N=5
      mode = 1'b0; sel_in = 3'd5; start = 1'b1;
      tick();
      start = 1'b0; sel_in = 3'($urandom); mode = 1'($urandom);
      total++;
      if (busy8 !== 1'b1 || valid8 !== 1'b0) begin
         bad++; $display("FAIL man_start1 busy=%b valid=%b exp busy=1 valid=0", busy8, valid8);
      end
      total++;
      if (err5 !== 1'b1 || busy5 !== 1'b1) begin
         bad++; $display("FAIL man_start_err5 err=%b busy=%b exp 1 1", err5, busy5);
      end
      tick();
      total++;
      if (valid8 !== 1'b1 || y8 !== 4'd8 || ych8 !== 3'd5) begin
         bad++; $display("FAIL man_sel5 valid=%b y=%0d ych=%0d exp 1 8 5", valid8, y8, ych8);
      end
      total++;
      if (err5 !== 1'b0 || y5 !== 4'd3 || ych5 !== 3'd0 || valid5 !== 1'b1) begin
         bad++; $display("FAIL man_bad_start5 err=%b y=%0d ych=%0d valid=%b exp 0 3 0 1", err5, y5, ych5, valid5);
      end
      // load 2
      load = 1'b1; sel_in = 3'd2;
      tick();
      load = 1'b0; sel_in = 3'($urandom);
      total++;
      if (y8 !== 4'd8) begin bad++; $display("FAIL man_load_lat y=%0d exp=8", y8); end
      tick();
      total++;
      if (y8 !== 4'd5 || ych8 !== 3'd2) begin
         bad++; $display("FAIL man_load2 y=%0d ych=%0d exp 5 2", y8, ych8);
      end
      // load 6: out of range for N=5 only
      load = 1'b1; sel_in = 3'd6;
      tick();
      load = 1'b0;
      total++;
      if (err5 !== 1'b1 || err8 !== 1'b0) begin
         bad++; $display("FAIL man_load_err err5=%b err8=%b exp 1 0", err5, err8);
      end
      tick();
      total++;
      if (err5 !== 1'b0 || y5 !== 4'd5 || ych5 !== 3'd2) begin
         bad++; $display("FAIL man_load_bad5 err=%b y=%0d ych=%0d exp 0 5 2", err5, y5, ych5);
      end
      total++;
      if (y8 !== 4'd9 || ych8 !== 3'd6) begin
         bad++; $display("FAIL man_load6_8 y=%0d ych=%0d exp 9 6", y8, ych8);
      end
      // randomized loads on the N=5 instance; stray scan starts must be ignored
      ch_m = 2;
      for (int i = 0; i < 40; i++) begin
         din5   = 20'($urandom);
         load   = ($urandom_range(0, 2) == 0);
         sel_in = 3'($urandom);
         start  = ($urandom_range(0, 4) == 0);
         mode   = 1'b1;
         dwell  = 8'($urandom);
         pd = din5; pch = ch_m;
         exp_err = load && (int'(sel_in) >= 5);
         if (load && int'(sel_in) < 5) ch_m = int'(sel_in);
         tick();
         total++;
         if (y5 !== pick5(pd, pch) || ych5 !== 3'(pch) || err5 !== exp_err || valid5 !== 1'b1) begin
            bad++;
            $display("FAIL man_rand i=%0d y=%0d ych=%0d err=%b valid=%b exp %0d %0d %b 1",
                     i, y5, ych5, err5, valid5, pick5(pd, pch), pch, exp_err);
         end
      end
      load = 1'b0; start = 1'b0; mode = 1'b0;
      go_idle();
      total++;
      if (valid5 !== 1'b0 || busy5 !== 1'b0) begin
         bad++; $display("FAIL man_stop valid=%b busy=%b exp 0 0", valid5, busy5);
      end
   endtask

   task automatic test_scan8(input int d, input int edges);
      logic [31:0] pd;
      int          exp_ch, wraps, per;
      logic        exp_wrap;
      per = (d + 1) * 8;
      wraps = 0;
      mode = 1'b1; dwell = 8'(d); start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= edges; k++) begin
         dwell  = 8'($urandom);
         sel_in = 3'($urandom);
         mode   = 1'($urandom);
         load   = 1'($urandom);
         din8   = $urandom;
         pd     = din8;
         tick();
         exp_ch   = ((k - 1) / (d + 1)) % 8;
         exp_wrap = (k % per == 0);
         if (wrap8 === 1'b1) wraps++;
         total++;
         if (ych8 !== 3'(exp_ch) || y8 !== pick8(pd, exp_ch) || valid8 !== 1'b1 || wrap8 !== exp_wrap) begin
            bad++;
            $display("FAIL scan8 d=%0d k=%0d ych=%0d y=%0d valid=%b wrap=%b exp %0d %0d 1 %b",
                     d, k, ych8, y8, valid8, wrap8, exp_ch, pick8(pd, exp_ch), exp_wrap);
         end
      end
      load = 1'b0;
      total++;
      if (wraps != edges / per) begin
         bad++; $display("FAIL scan8_wrap_count d=%0d got=%0d exp=%0d", d, wraps, edges / per);
      end
      go_idle();
   endtask

   task automatic test_scan5_stop();
      mode = 1'b1; dwell = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         total++;
         if (ych5 !== 3'((k - 1) % 5) || wrap5 !== (k % 5 == 0)) begin
            bad++;
            $display("FAIL scan5 k=%0d ych=%0d wrap=%b exp %0d %b", k, ych5, wrap5, (k - 1) % 5, (k % 5 == 0));
         end
      end
      // stop lands on the 4->0 advance
      stop = 1'b1;
      tick();
      stop = 1'b0;
      total++;
      if (wrap5 !== 1'b0 || valid5 !== 1'b0 || busy5 !== 1'b0) begin
         bad++; $display("FAIL scan5_stop wrap=%b valid=%b busy=%b exp 0 0 0", wrap5, valid5, busy5);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      mode = 1'b1; dwell = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (ych8 !== 3'd3 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (ych8 !== 3'd3) begin
         bad++; $display("FAIL reset_mid_reach ych=%0d exp=3", ych8);
      end
      rst = 1'b1; start = 1'b1; load = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; load = 1'b0;
      total++;
      if ({y8, ych8, valid8, busy8, wrap8, err8} !== 11'd0) begin
         bad++; $display("FAIL reset_mid got=%h exp=0", {y8, ych8, valid8, busy8, wrap8, err8});
      end
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      total++;
      if (busy8 !== 1'b0 || busy5 !== 1'b0) begin
         bad++; $display("FAIL start_stop busy8=%b busy5=%b exp 0 0", busy8, busy5);
      end
      tick();
      total++;
      if (busy8 !== 1'b0 || valid8 !== 1'b0) begin
         bad++; $display("FAIL start_stop_hold busy=%b valid=%b exp 0 0", busy8, valid8);
      end
   endtask

`ifdef MUX_SCAN_SKIP_MASK_EN
   task automatic test_mask();
      int exp_seq [6] = '{2, 5, 7, 2, 5, 7};
      en_mask8 = 8'b1010_0100;
      mode = 1'b1; dwell = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++;
         if (ych8 !== 3'(exp_seq[k-1]) || wrap8 !== (exp_seq[k-1] == 7) || valid8 !== 1'b1) begin
            bad++;
            $display("FAIL mask_seq k=%0d ych=%0d wrap=%b valid=%b exp %0d %b 1",
                     k, ych8, wrap8, valid8, exp_seq[k-1], (exp_seq[k-1] == 7));
         end
      end
      en_mask8 = 8'd0;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if (valid8 !== 1'b0 || ych8 !== 3'd2 || wrap8 !== 1'b0) begin
            bad++; $display("FAIL mask_zero valid=%b ych=%0d wrap=%b exp 0 2 0", valid8, ych8, wrap8);
         end
      end
      en_mask8 = 8'b0001_0000;
      tick();
      total++;
      if (valid8 !== 1'b1 || ych8 !== 3'd2 || wrap8 !== 1'b0) begin
         bad++; $display("FAIL mask_resume valid=%b ych=%0d wrap=%b exp 1 2 0", valid8, ych8, wrap8);
      end
      tick();
      total++;
      if (ych8 !== 3'd4 || wrap8 !== 1'b1) begin
         bad++; $display("FAIL mask_single ych=%0d wrap=%b exp 4 1", ych8, wrap8);
      end
      en_mask8 = 8'hFF;
      go_idle();
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mode = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
      sel_in = '0; dwell = '0; din8 = '0; din5 = '0;
`ifdef MUX_SCAN_SKIP_MASK_EN
      en_mask8 = 8'hFF;
      en_mask5 = 5'h1F;
`endif
      test_reset();
      test_manual();
      test_scan8(2, 48);
      for (int r = 0; r < 3; r++) test_scan8(int'($urandom_range(0, 3)), 40);
      test_scan5_stop();
      test_reset_mid();
`ifdef MUX_SCAN_SKIP_MASK_EN
      test_mask();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
